regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive cycles a queued port-1 write may be denied the write port.
REQ-002 SHALL have parameter Q_DEPTH, default 2: port-1 queue entries.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  core writeback request valid.
REQ-006 req0_rd  input  5  core destination register.
REQ-007 req0_data  input  32  core write data.
REQ-008 req0_ready  output  1  core request consumed this cycle.
REQ-009 req1_valid  input  1  multi-cycle unit (load/div) writeback request valid.
REQ-010 req1_rd  input  5  multi-cycle unit destination register.
REQ-011 req1_data  input  32  multi-cycle unit write data.
REQ-012 req1_ready  output  1  port-1 request accepted into queue this cycle.
REQ-013 rf_write_en  output  1  register file write enable.
REQ-014 rf_rd  output  5  register file write address.
REQ-015 rf_write_data  output  32  register file write data.
REQ-016 pending  output  32  bit i set while any queued entry targets register i; the core stalls source reads on it.

Function
REQ-017 Transfers SHALL occur when valid and ready are both high at a rising edge.
REQ-018 Port-1 requests SHALL enter a FIFO of Q_DEPTH entries; req1_ready = !rst && !full; no push-through when full, even if the head pops that cycle.
REQ-019 Write-port outputs SHALL be combinational from the same-cycle grant; the register file samples them on the following falling edge.
REQ-020 Grant priority each cycle: (a) FIFO head if non-empty and starve_cnt == STARVE_LIMIT; else (b) req0 if req0_valid and not blocked; else (c) FIFO head if non-empty; else none.
REQ-021 req0 SHALL be blocked when req0_rd != 0 and pending[req0_rd] == 1 (write-after-write ordering); req0_ready = !rst && req0_valid-independent grant eligibility, i.e. high only when req0 would win the grant.
REQ-022 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and the head is not granted, and clear when the head is granted or the FIFO is empty.
REQ-023 A granted request with rd == 0 SHALL be consumed (ready/pop) with rf_write_en = 0.
REQ-024 rf_write_en SHALL be 1 only when a grant exists and its rd != 0; rf_rd and rf_write_data carry the granted request, else 0.
REQ-025 Port-1 minimum latency SHALL be 1 cycle (accept at edge N, earliest write port drive in cycle N+1); port-0 latency 0 cycles.
REQ-026 pending SHALL reflect FIFO contents after the current edge; pending[0] is always 0; an entry pushed and an entry popped in one cycle SHALL update the mask correctly, including for equal rd.
REQ-027 FIFO pointers SHALL wrap modulo Q_DEPTH; occupancy SHALL be tracked by an explicit count of 0..Q_DEPTH.

Reset
REQ-028 While rst is high: FIFO emptied, starve_cnt = 0, req0_ready = 0, req1_ready = 0, rf_write_en = 0, rf_rd = 0, rf_write_data = 0, pending = 0.
REQ-029 Reset asserted mid-operation SHALL discard queued writes without driving the write port; the first grant occurs in the cycle after rst deasserts.

Structure
REQ-030 Shared package wb_arb_pkg SHALL hold wb_req_t (rd 5 bits, data 32 bits) and default constants for STARVE_LIMIT and Q_DEPTH.
REQ-031 The port-1 queue SHALL be a sub-module wb_fifo (parameterised depth, push/pop/full/empty/count, entry array exposed for pending generation).

Verification
REQ-032 After reset, req0 {rd=5, data=0xDEADBEEF} -> same cycle rf_write_en=1, rf_rd=5, rf_write_data=0xDEADBEEF, req0_ready=1.
REQ-033 req1 {rd=7, data=0x11} while req0 idle -> pending[7]=1 next cycle, write of 0x11 to x7 that cycle, pending[7]=0 after.
REQ-034 req1 {rd=3} queued, req0 writes x9 every cycle -> head denied 4 cycles, granted in 5th cycle with req0_ready=0 that cycle.
REQ-035 req1 {rd=4} queued, req0 {rd=4} same cycle -> req0_ready=0, queued x4 written first, req0 x4 written next cycle.
REQ-036 Two req1 pushes fill queue, third req1_valid -> req1_ready=0 until a pop; req0 {rd=0} -> req0_ready=1, rf_write_en=0.
REQ-037 Assert rst with two queued entries -> no write-port activity, pending=0, req1_ready=0 during rst, queue empty afterward.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_arb_pkg;

    localparam int unsigned REG_AW           = 5;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned NUM_REGS         = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned Q_DEPTH_DEF      = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // One-hot register mask; x0 is never tracked.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [NUM_REGS-1:0] m;
        m    = NUM_REGS'(1) << rd;
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request ports, register-file write port and pending mask.
interface regfile_wb_arbiter_if;
    import wb_arb_pkg::*;

    logic                req0_valid;
    logic [REG_AW-1:0]   req0_rd;
    logic [DATA_W-1:0]   req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [REG_AW-1:0]   req1_rd;
    logic [DATA_W-1:0]   req1_data;
    logic                req1_ready;
    logic                rf_write_en;
    logic [REG_AW-1:0]   rf_rd;
    logic [DATA_W-1:0]   rf_write_data;
    logic [NUM_REGS-1:0] pending;

    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        input  req0_ready, req1_ready, rf_write_en, rf_rd, rf_write_data, pending
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        output req0_ready, req1_ready, rf_write_en, rf_rd, rf_write_data, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Port-1 writeback queue: circular buffer with explicit occupancy count.
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = Q_DEPTH_DEF,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wb_req_t           push_req,
    input  logic              pop,
    output wb_req_t           head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [REG_AW-1:0] entry_rd [DEPTH],
    output logic [DEPTH-1:0]  entry_valid
);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= push_req;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Slot i is live when it lies in the circular range [rd_ptr, wr_ptr).
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_rd[i] = mem[i].rd;
            if (full)
                entry_valid[i] = 1'b1;
            else if (wr_ptr >= rd_ptr)
                entry_valid[i] = (PTR_W'(i) >= rd_ptr) && (PTR_W'(i) < wr_ptr);
            else
                entry_valid[i] = (PTR_W'(i) >= rd_ptr) || (PTR_W'(i) < wr_ptr);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates core (port 0) and queued multi-cycle unit (port 1) writebacks onto one RF write port.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned Q_DEPTH      = Q_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave wb
);

    localparam int unsigned SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);

    wb_req_t             push_req;
    wb_req_t             head;
    wb_req_t             grant_req;
    logic                push;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    count;
    logic [REG_AW-1:0]   entry_rd [Q_DEPTH];
    logic [Q_DEPTH-1:0]  entry_valid;
    logic [NUM_REGS-1:0] fifo_mask;
    logic [SC_W-1:0]     starve_cnt;
    logic                head_starved;
    logic                req0_blocked;
    logic                req0_eligible;
    logic                grant_req0;
    logic                grant_head;

    assign push_req = '{rd: wb.req1_rd, data: wb.req1_data};

    wb_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_req    (push_req),
        .pop         (grant_head),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    // Registers targeted by any queued entry.
    always_comb begin
        fifo_mask = '0;
        for (int i = 0; i < int'(Q_DEPTH); i++) begin
            if (entry_valid[i]) fifo_mask = fifo_mask | rd_onehot(entry_rd[i]);
        end
    end

    // A same-cycle port-1 push to the same rd is older than req0, so it blocks req0 too.
    always_comb begin
        push          = 1'b0;
        head_starved  = 1'b0;
        req0_blocked  = 1'b0;
        req0_eligible = 1'b0;
        grant_req0    = 1'b0;
        grant_head    = 1'b0;
        grant_req     = '0;
        if (!rst) begin
            push          = wb.req1_valid && !full;
            head_starved  = !empty && (starve_cnt == SC_W'(STARVE_LIMIT));
            req0_blocked  = (wb.req0_rd != '0) &&
                            (fifo_mask[wb.req0_rd] || (push && (wb.req1_rd == wb.req0_rd)));
            req0_eligible = !head_starved && !req0_blocked;
            grant_req0    = req0_eligible && wb.req0_valid;
            grant_head    = !grant_req0 && !empty;
            if (grant_req0)
                grant_req = '{rd: wb.req0_rd, data: wb.req0_data};
            else if (grant_head)
                grant_req = head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (empty || grant_head)
            starve_cnt <= '0;
        else if (starve_cnt != SC_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + SC_W'(1);
    end

    assign wb.req0_ready    = req0_eligible;
    assign wb.req1_ready    = !rst && !full;
    assign wb.rf_write_en   = (grant_req0 || grant_head) && (grant_req.rd != '0);
    assign wb.rf_rd         = grant_req.rd;
    assign wb.rf_write_data = grant_req.data;
    assign wb.pending       = rst ? '0 : fifo_mask;

    assert property (@(posedge clk) disable iff (rst)
        (32'(count) <= Q_DEPTH) && (empty == (count == '0)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_regfile_wb_arbiter;
    import wb_arb_pkg::*;

    localparam int LIMIT = STARVE_LIMIT_DEF;
    localparam int QD    = Q_DEPTH_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter_if wbif ();

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .Q_DEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wbif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: queue of pending port-1 writes plus a starvation age.
    wb_req_t q[$];
    int      starve = 0;

    always @(negedge clk) begin : ref_model
        logic [31:0] mask;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_r0rdy, e_r1rdy, e_wen;
        bit          push, blocked, g0, gh;
        wb_req_t     sel;
        mask = '0; e_data = '0; e_rd = '0; e_r0rdy = 0; e_r1rdy = 0; e_wen = 0;
        if (rst) begin
            q.delete();
            starve = 0;
        end else begin
            foreach (q[i]) mask = mask | (32'd1 << q[i].rd);
            mask[0] = 1'b0;
            e_r1rdy = (q.size() < QD);
            push    = wbif.req1_valid && e_r1rdy;
            blocked = (wbif.req0_rd != 5'd0) &&
                      (mask[wbif.req0_rd] || (push && wbif.req1_rd == wbif.req0_rd));
            e_r0rdy = !blocked && !(q.size() > 0 && starve >= LIMIT);
            g0      = e_r0rdy && wbif.req0_valid;
            gh      = !g0 && q.size() > 0;
            sel     = '0;
            if (g0)      sel = '{rd: wbif.req0_rd, data: wbif.req0_data};
            else if (gh) sel = q[0];
            e_wen  = (g0 || gh) && sel.rd != 5'd0;
            e_rd   = sel.rd;
            e_data = sel.data;
            if (q.size() == 0 || gh) starve = 0;
            else if (starve < LIMIT) starve++;
            if (gh)   void'(q.pop_front());
            if (push) q.push_back('{rd: wbif.req1_rd, data: wbif.req1_data});
        end
        chk("model_req0_ready", 32'(wbif.req0_ready), 32'(e_r0rdy));
        chk("model_req1_ready", 32'(wbif.req1_ready), 32'(e_r1rdy));
        chk("model_rf_write_en", 32'(wbif.rf_write_en), 32'(e_wen));
        chk("model_rf_rd", 32'(wbif.rf_rd), 32'(e_rd));
        chk("model_rf_write_data", wbif.rf_write_data, e_data);
        chk("model_pending", wbif.pending, rst ? 32'd0 : mask);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        wbif.req0_valid = v0; wbif.req0_rd = r0; wbif.req0_data = d0;
        wbif.req1_valid = v1; wbif.req1_rd = r1; wbif.req1_data = d1;
    endtask

    initial begin
        bit found;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("reset_req0_ready", 32'(wbif.req0_ready), 32'd0);
        chk("reset_req1_ready", 32'(wbif.req1_ready), 32'd0);
        chk("reset_rf_write_en", 32'(wbif.rf_write_en), 32'd0);
        chk("reset_pending", wbif.pending, 32'd0);
        step();
        rst = 1'b0;

        // Core write goes straight through in the same cycle.
        drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("p0_wen", 32'(wbif.rf_write_en), 32'd1);
        chk("p0_rd", 32'(wbif.rf_rd), 32'd5);
        chk("p0_data", wbif.rf_write_data, 32'hDEADBEEF);
        chk("p0_ready", 32'(wbif.req0_ready), 32'd1);

        // Port-1 write: queued, pending, then written one cycle later.
        step(); drive(0, 5'd0, 32'h0, 1, 5'd7, 32'h11);
        @(negedge clk);
        chk("p1_accept", 32'(wbif.req1_ready), 32'd1);
        chk("p1_no_write_yet", 32'(wbif.rf_write_en), 32'd0);
        step(); drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("p1_pending7", wbif.pending, 32'h0000_0080);
        chk("p1_write_rd", 32'(wbif.rf_rd), 32'd7);
        chk("p1_write_data", wbif.rf_write_data, 32'h11);
        step();
        @(negedge clk);
        chk("p1_pending_clear", wbif.pending, 32'd0);

        // Starvation: core hogs the port, head wins on the fifth cycle.
        step(); drive(1, 5'd9, 32'h99, 1, 5'd3, 32'h33);
        @(negedge clk);
        chk("starve_push_cycle_rd", 32'(wbif.rf_rd), 32'd9);
        step(); drive(1, 5'd9, 32'h99, 0, 5'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("starve_denied_rd", 32'(wbif.rf_rd), 32'd9);
            step();
        end
        @(negedge clk);
        chk("starve_grant_rd", 32'(wbif.rf_rd), 32'd3);
        chk("starve_grant_data", wbif.rf_write_data, 32'h33);
        chk("starve_req0_ready", 32'(wbif.req0_ready), 32'd0);
        step(); drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Same-rd collision: queued x4 must land before the core's x4.
        step(); drive(1, 5'd4, 32'hB, 1, 5'd4, 32'hA);
        @(negedge clk);
        chk("waw_req0_ready0", 32'(wbif.req0_ready), 32'd0);
        chk("waw_no_write", 32'(wbif.rf_write_en), 32'd0);
        step(); drive(1, 5'd4, 32'hB, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("waw_first_data", wbif.rf_write_data, 32'hA);
        chk("waw_first_req0_ready", 32'(wbif.req0_ready), 32'd0);
        step();
        @(negedge clk);
        chk("waw_second_data", wbif.rf_write_data, 32'hB);
        chk("waw_second_req0_ready", 32'(wbif.req0_ready), 32'd1);
        step(); drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Fill the queue while x0 core writes win; no push-through on pop.
        step(); drive(1, 5'd0, 32'h5, 1, 5'd1, 32'h101);
        step(); drive(1, 5'd0, 32'h6, 1, 5'd2, 32'h102);
        step(); drive(1, 5'd0, 32'h7, 1, 5'd6, 32'h106);
        @(negedge clk);
        chk("full_req1_ready", 32'(wbif.req1_ready), 32'd0);
        chk("x0_req0_ready", 32'(wbif.req0_ready), 32'd1);
        chk("x0_no_write", 32'(wbif.rf_write_en), 32'd0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            @(negedge clk);
            if (wbif.rf_write_en) begin
                found = 1;
                chk("full_pop_rd", 32'(wbif.rf_rd), 32'd1);
                chk("full_pop_no_pushthrough", 32'(wbif.req1_ready), 32'd0);
            end
        end
        if (!found) chk("full_pop_timeout", 32'd0, 32'd1);
        step();
        @(negedge clk);
        chk("after_pop_req1_ready", 32'(wbif.req1_ready), 32'd1);
        step(); drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        repeat (3) step();

        // Reset with two queued entries discards them silently.
        drive(1, 5'd0, 32'h0, 1, 5'd10, 32'hA0A);
        step(); drive(1, 5'd0, 32'h0, 1, 5'd11, 32'hB0B);
        step(); rst = 1'b1; drive(0, 5'd0, 32'h0, 1, 5'd12, 32'hC0C);
        @(negedge clk);
        chk("rst_mid_wen", 32'(wbif.rf_write_en), 32'd0);
        chk("rst_mid_pending", wbif.pending, 32'd0);
        chk("rst_mid_req1_ready", 32'(wbif.req1_ready), 32'd0);
        step();
        @(negedge clk);
        chk("rst_hold_wen", 32'(wbif.rf_write_en), 32'd0);
        step(); rst = 1'b0; drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("rst_after_pending", wbif.pending, 32'd0);
        chk("rst_after_wen", 32'(wbif.rf_write_en), 32'd0);
        chk("rst_after_req1_ready", 32'(wbif.req1_ready), 32'd1);

        // Randomized traffic with a small rd range to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom);
        end
        step(); rst = 1'b0; drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        repeat (4) step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
